// File: rtl/des_pkg.sv
// Shared definitions for the DES S-box substitution layer.
//   - state_e        : controller state encoding (IDLE / RUN / DONE)
//   - S_TABLE        : the eight DES S-box tables, S_TABLE[box][addr], where
//                      box 0 is S1 and addr = {b6,b1,b5,b4,b3,b2}
//   - box_chunk_lsb  : LSB position of a box's 6-bit chunk in the 48-bit input word
//   - box_nibble_lsb : LSB position of a box's 4-bit nibble in the 32-bit result word
//   - odd_parity     : per-nibble odd parity, bit 7 corresponds to S1
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int NUM_BOXES = 8;

  // Each inner list is one box, stored row-major: four rows of sixteen columns.
  localparam logic [3:0] S_TABLE [NUM_BOXES][64] = '{
    '{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7,
      4'h0,4'hF,4'h7,4'h4,4'hE,4'h2,4'hD,4'h1,4'hA,4'h6,4'hC,4'hB,4'h9,4'h5,4'h3,4'h8,
      4'h4,4'h1,4'hE,4'h8,4'hD,4'h6,4'h2,4'hB,4'hF,4'hC,4'h9,4'h7,4'h3,4'hA,4'h5,4'h0,
      4'hF,4'hC,4'h8,4'h2,4'h4,4'h9,4'h1,4'h7,4'h5,4'hB,4'h3,4'hE,4'hA,4'h0,4'h6,4'hD},
    '{4'hF,4'h1,4'h8,4'hE,4'h6,4'hB,4'h3,4'h4,4'h9,4'h7,4'h2,4'hD,4'hC,4'h0,4'h5,4'hA,
      4'h3,4'hD,4'h4,4'h7,4'hF,4'h2,4'h8,4'hE,4'hC,4'h0,4'h1,4'hA,4'h6,4'h9,4'hB,4'h5,
      4'h0,4'hE,4'h7,4'hB,4'hA,4'h4,4'hD,4'h1,4'h5,4'h8,4'hC,4'h6,4'h9,4'h3,4'h2,4'hF,
      4'hD,4'h8,4'hA,4'h1,4'h3,4'hF,4'h4,4'h2,4'hB,4'h6,4'h7,4'hC,4'h0,4'h5,4'hE,4'h9},
    '{4'hA,4'h0,4'h9,4'hE,4'h6,4'h3,4'hF,4'h5,4'h1,4'hD,4'hC,4'h7,4'hB,4'h4,4'h2,4'h8,
      4'hD,4'h7,4'h0,4'h9,4'h3,4'h4,4'h6,4'hA,4'h2,4'h8,4'h5,4'hE,4'hC,4'hB,4'hF,4'h1,
      4'hD,4'h6,4'h4,4'h9,4'h8,4'hF,4'h3,4'h0,4'hB,4'h1,4'h2,4'hC,4'h5,4'hA,4'hE,4'h7,
      4'h1,4'hA,4'hD,4'h0,4'h6,4'h9,4'h8,4'h7,4'h4,4'hF,4'hE,4'h3,4'hB,4'h5,4'h2,4'hC},
    '{4'h7,4'hD,4'hE,4'h3,4'h0,4'h6,4'h9,4'hA,4'h1,4'h2,4'h8,4'h5,4'hB,4'hC,4'h4,4'hF,
      4'hD,4'h8,4'hB,4'h5,4'h6,4'hF,4'h0,4'h3,4'h4,4'h7,4'h2,4'hC,4'h1,4'hA,4'hE,4'h9,
      4'hA,4'h6,4'h9,4'h0,4'hC,4'hB,4'h7,4'hD,4'hF,4'h1,4'h3,4'hE,4'h5,4'h2,4'h8,4'h4,
      4'h3,4'hF,4'h0,4'h6,4'hA,4'h1,4'hD,4'h8,4'h9,4'h4,4'h5,4'hB,4'hC,4'h7,4'h2,4'hE},
    '{4'h2,4'hC,4'h4,4'h1,4'h7,4'hA,4'hB,4'h6,4'h8,4'h5,4'h3,4'hF,4'hD,4'h0,4'hE,4'h9,
      4'hE,4'hB,4'h2,4'hC,4'h4,4'h7,4'hD,4'h1,4'h5,4'h0,4'hF,4'hA,4'h3,4'h9,4'h8,4'h6,
      4'h4,4'h2,4'h1,4'hB,4'hA,4'hD,4'h7,4'h8,4'hF,4'h9,4'hC,4'h5,4'h6,4'h3,4'h0,4'hE,
      4'hB,4'h8,4'hC,4'h7,4'h1,4'hE,4'h2,4'hD,4'h6,4'hF,4'h0,4'h9,4'hA,4'h4,4'h5,4'h3},
    '{4'hC,4'h1,4'hA,4'hF,4'h9,4'h2,4'h6,4'h8,4'h0,4'hD,4'h3,4'h4,4'hE,4'h7,4'h5,4'hB,
      4'hA,4'hF,4'h4,4'h2,4'h7,4'hC,4'h9,4'h5,4'h6,4'h1,4'hD,4'hE,4'h0,4'hB,4'h3,4'h8,
      4'h9,4'hE,4'hF,4'h5,4'h2,4'h8,4'hC,4'h3,4'h7,4'h0,4'h4,4'hA,4'h1,4'hD,4'hB,4'h6,
      4'h4,4'h3,4'h2,4'hC,4'h9,4'h5,4'hF,4'hA,4'hB,4'hE,4'h1,4'h7,4'h6,4'h0,4'h8,4'hD},
    '{4'h4,4'hB,4'h2,4'hE,4'hF,4'h0,4'h8,4'hD,4'h3,4'hC,4'h9,4'h7,4'h5,4'hA,4'h6,4'h1,
      4'hD,4'h0,4'hB,4'h7,4'h4,4'h9,4'h1,4'hA,4'hE,4'h3,4'h5,4'hC,4'h2,4'hF,4'h8,4'h6,
      4'h1,4'h4,4'hB,4'hD,4'hC,4'h3,4'h7,4'hE,4'hA,4'hF,4'h6,4'h8,4'h0,4'h5,4'h9,4'h2,
      4'h6,4'hB,4'hD,4'h8,4'h1,4'h4,4'hA,4'h7,4'h9,4'h5,4'h0,4'hF,4'hE,4'h2,4'h3,4'hC},
    '{4'hD,4'h2,4'h8,4'h4,4'h6,4'hF,4'hB,4'h1,4'hA,4'h9,4'h3,4'hE,4'h5,4'h0,4'hC,4'h7,
      4'h1,4'hF,4'hD,4'h8,4'hA,4'h3,4'h7,4'h4,4'hC,4'h5,4'h6,4'hB,4'h0,4'hE,4'h9,4'h2,
      4'h7,4'hB,4'h4,4'h1,4'h9,4'hC,4'hE,4'h2,4'h0,4'h6,4'hA,4'hD,4'hF,4'h3,4'h5,4'h8,
      4'h2,4'h1,4'hE,4'h7,4'h4,4'hA,4'h8,4'hD,4'hF,4'hC,4'h9,4'h0,4'h3,4'h5,4'h6,4'hB}
  };

  // S1 occupies the top six bits of the input word, S8 the bottom six.
  function automatic logic [5:0] box_chunk_lsb(input logic [2:0] box);
    return 6'd42 - ({1'b0, box, 2'b00} + {2'b00, box, 1'b0});
  endfunction

  // S1 occupies the top nibble of the result word, S8 the bottom nibble.
  function automatic logic [4:0] box_nibble_lsb(input logic [2:0] box);
    return 5'd28 - {box, 2'b00};
  endfunction

  // An all-zero nibble has odd parity 1, so a cleared result word maps to 8'hFF.
  function automatic logic [7:0] odd_parity(input logic [31:0] w);
    return {~^w[31:28], ~^w[27:24], ~^w[23:20], ~^w[19:16],
            ~^w[15:12], ~^w[11:8],  ~^w[7:4],   ~^w[3:0]};
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Single DES S-box lookup, purely combinational.
// Ports:
//   box    in  [2:0] which S-box (0 = S1 ... 7 = S8)
//   chunk  in  [5:0] six input bits b6..b1 (chunk[5] = b6)
//   nibble out [3:0] substituted value
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] chunk,
  output logic [3:0] nibble
);

  // Outer bits select the row, inner four bits the column.
  logic [5:0] addr;

  assign addr   = {chunk[5], chunk[0], chunk[4:1]};
  assign nibble = S_TABLE[box][addr];

endmodule

// File: rtl/des_sbox_layer.sv
// Time-multiplexed DES S-box layer: substitutes a 48-bit word into a 32-bit
// word using LANES lookups per cycle, so a word needs 8/LANES compute beats.
// Optional build macro DES_SBOX_PARITY_EN adds the out_par port.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_data[48:43] feeds S1 ... [6:1] feeds S8
//   out_valid/out_ready  output handshake, out_data[32:29] = S1 ... [4:1] = S8
//   out_par[8:1]         (DES_SBOX_PARITY_EN only) odd parity per nibble, [8] = S1
//   busy                 high while a word is being computed or held for output
module des_sbox_layer
  import des_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:1] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] out_data,
`ifdef DES_SBOX_PARITY_EN
  output logic [8:1]  out_par,
`endif
  output logic        busy
);

  localparam int BEATS  = 8 / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_layer: LANES must be 1, 2, 4 or 8");
  end

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [47:0]       in_reg_q, in_reg_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       out_q, out_d;

  logic [2:0]  lane_box   [LANES];
  logic [3:0]  lane_nib   [LANES];
  logic [31:0] lane_merge [LANES+1];

  // Each lane reads its chunk from the captured input word and splices its
  // nibble into the partial result; the chain gives this beat's full update.
  assign lane_merge[0] = acc_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [5:0] chunk;
    logic [4:0] pos;

    assign lane_box[j] = 3'(int'(beat_q) * LANES + j);
    assign chunk       = in_reg_q[box_chunk_lsb(lane_box[j]) +: 6];
    assign pos         = box_nibble_lsb(lane_box[j]);

    des_sbox_lut u_lut (
      .box    (lane_box[j]),
      .chunk  (chunk),
      .nibble (lane_nib[j])
    );

    assign lane_merge[j+1] = (lane_merge[j] & ~(32'hF << pos)) | (32'(lane_nib[j]) << pos);
  end

  // Controller: partial results live in acc_q so out_data only changes when
  // the final beat completes the word.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    in_reg_d = in_reg_q;
    acc_d    = acc_q;
    out_d    = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_reg_d = in_data;
          beat_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = lane_merge[LANES];
        if (beat_q == LAST_BEAT) begin
          out_d   = lane_merge[LANES];
          beat_d  = '0;
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            in_reg_d = in_data;
            beat_d   = '0;
            state_d  = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      in_reg_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      in_reg_q <= in_reg_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_q;

`ifdef DES_SBOX_PARITY_EN
  // Parity tracks the next output word, so it always matches out_q exactly.
  logic [7:0] par_q, par_d;

  assign par_d = odd_parity(out_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 8'hFF;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_des_sbox_layer.sv
// Self-checking bench for des_sbox_layer. Three instances (LANES = 1, 2, 8)
// share clock and reset; expected results come from an independent copy of
// the DES tables and are queued when a word is accepted.
module tb_des_sbox_layer;

  localparam int NDUT = 3;
  localparam int LANE_CFG [NDUT] = '{1, 2, 8};
  localparam int BEAT_CFG [NDUT] = '{8, 4, 1};

  // Reference tables: each box is 64 nibbles, row-major, first entry in the MSBs.
  localparam logic [255:0] REF_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef struct {
    logic [47:0] din;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  par;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [48:1] in_data   [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [32:1] out_data  [NDUT];
  logic        busy      [NDUT];
`ifdef DES_SBOX_PARITY_EN
  logic [8:1]  out_par   [NDUT];
`endif

  int   n_vec;
  int   n_miss;
  exp_t sb_q [$];
  vec_t vecs [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    des_sbox_layer #(.LANES(LANE_CFG[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
`ifdef DES_SBOX_PARITY_EN
      .out_par   (out_par[g]),
`endif
      .busy      (busy[g])
    );
  end

  // Reference substitution: row from the outer bits, column from the inner four.
  function automatic logic [31:0] ref_layer(input logic [47:0] d);
    logic [31:0]  r;
    logic [255:0] t;
    logic [5:0]   v;
    int           idx;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v   = d[47-6*k -: 6];
      idx = int'({v[5], v[0]}) * 16 + int'(v[4:1]);
      t   = REF_TAB[k];
      r[31-4*k -: 4] = t[255-4*idx -: 4];
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_par(input logic [31:0] w);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) p[7-k] = ~^w[31-4*k -: 4];
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_vec++;
    n_miss++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input int d, input logic [47:0] din, input logic [31:0] dout);
    exp_t e;
    for (int t = 0; t < 50 && !in_ready[d]; t++) @(negedge clk);
    if (!in_ready[d]) begin
      reportTimeout($sformatf("L%0d in_ready", LANE_CFG[d]));
      return;
    end
    in_valid[d] = 1'b1;
    in_data[d]  = din;
    @(posedge clk);
    e.data = dout;
    e.par  = ref_par(dout);
    sb_q.push_back(e);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // Called at the negedge following the accepting edge; returns at the first
  // negedge where out_valid is seen.
  task automatic collectOutput(input int d, input string tag);
    int   edges;
    logic ready_bad;
    logic busy_bad;
    exp_t e;
    edges     = 0;
    ready_bad = 1'b0;
    busy_bad  = 1'b0;
    while (!out_valid[d] && edges < 40) begin
      if (in_ready[d]) ready_bad = 1'b1;
      if (!busy[d]) busy_bad = 1'b1;
      @(negedge clk);
      edges++;
    end
    if (!out_valid[d]) begin
      reportTimeout({tag, " out_valid"});
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    checkOutput({tag, " latency"}, 32'(edges), 32'(BEAT_CFG[d]));
    checkOutput({tag, " in_ready high in RUN"}, 32'(ready_bad), 32'd0);
    checkOutput({tag, " busy low in RUN"}, 32'(busy_bad), 32'd0);
    if (sb_q.size() == 0) begin
      reportTimeout({tag, " scoreboard empty"});
      return;
    end
    e = sb_q.pop_front();
    checkOutput({tag, " out_data"}, out_data[d], e.data);
`ifdef DES_SBOX_PARITY_EN
    checkOutput({tag, " out_par"}, 32'(out_par[d]), 32'(e.par));
`endif
  endtask

  task automatic checkIdleReset(input int d, input string tag);
    checkOutput($sformatf("%s L%0d out_valid", tag, LANE_CFG[d]), 32'(out_valid[d]), 32'd0);
    checkOutput($sformatf("%s L%0d out_data", tag, LANE_CFG[d]), out_data[d], 32'd0);
    checkOutput($sformatf("%s L%0d busy", tag, LANE_CFG[d]), 32'(busy[d]), 32'd0);
    checkOutput($sformatf("%s L%0d in_ready", tag, LANE_CFG[d]), 32'(in_ready[d]), 32'd1);
`ifdef DES_SBOX_PARITY_EN
    checkOutput($sformatf("%s L%0d out_par", tag, LANE_CFG[d]), 32'(out_par[d]), 32'hFF);
`endif
  endtask

  // Watchdog so the run always ends on its own.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] din;
    n_vec = 0;
    n_miss = 0;

    vecs[0] = '{48'h000000000000, 32'hEFA72C4D};
    vecs[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[2] = '{48'h0123456789AB, ref_layer(48'h0123456789AB)};
    vecs[3] = '{48'hA5A5A5A5A5A5, ref_layer(48'hA5A5A5A5A5A5)};
    vecs[4] = '{48'h800000000001, ref_layer(48'h800000000001)};
    vecs[5] = '{48'h3C0FF0C3AA55, ref_layer(48'h3C0FF0C3AA55)};

    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) checkIdleReset(d, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors on every lane configuration.
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 6; i++) begin
        applyStimulus(d, vecs[i].din, vecs[i].dout);
        collectOutput(d, $sformatf("L%0d vec%0d", LANE_CFG[d], i));
      end
    end
    repeat (2) @(negedge clk);

    // Backpressure: result must hold while downstream stalls, then hand over
    // to the next word on the same edge.
    out_ready[1] = 1'b0;
    applyStimulus(1, 48'h0123456789AB, ref_layer(48'h0123456789AB));
    collectOutput(1, "bp first");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d out_data", c), out_data[1], ref_layer(48'h0123456789AB));
      checkOutput($sformatf("bp hold%0d out_valid", c), 32'(out_valid[1]), 32'd1);
      checkOutput($sformatf("bp hold%0d in_ready", c), 32'(in_ready[1]), 32'd0);
    end
    begin
      exp_t e;
      in_valid[1]  = 1'b1;
      in_data[1]   = 48'hFFFFFFFFFFFF;
      out_ready[1] = 1'b1;
      @(posedge clk);
      e.data = 32'hD9CE3DCB;
      e.par  = ref_par(32'hD9CE3DCB);
      sb_q.push_back(e);
      @(negedge clk);
      in_valid[1] = 1'b0;
      checkOutput("handover out_valid", 32'(out_valid[1]), 32'd0);
      checkOutput("handover busy", 32'(busy[1]), 32'd1);
      checkOutput("handover in_ready", 32'(in_ready[1]), 32'd0);
      collectOutput(1, "bp second");
    end
    repeat (2) @(negedge clk);

    // Mid-RUN reset on LANES=1: abort during beat 2, then a fresh word.
    applyStimulus(0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdleReset(0, "mid-run reset");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 48'h000000000000, 32'hEFA72C4D);
    collectOutput(0, "post-reset zero");
    repeat (2) @(negedge clk);

    // Sweep every box with every 6-bit value, other chunks zero.
    for (int k = 0; k < 8; k++) begin
      for (int v = 0; v < 64; v++) begin
        din = 48'(v) << (42 - 6 * k);
        applyStimulus(1, din, ref_layer(din));
        collectOutput(1, $sformatf("sweep S%0d v%0d", k + 1, v));
      end
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
